// File: rtl/exp_seq_pkg.sv
// Shared types and helpers for the Taylor-series exp sequencer.
// The defaults match the exp core configuration.
package exp_seq_pkg;

    localparam int unsigned FwDef      = 12;
    localparam int unsigned MaxTermDef = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StDrain,
        StHold
    } seq_state_e;

    // A budget of 0 or >= max_term is clipped to max_term-1. The core then never hits its
    // terminal count before oDataRead has been raised.
    function automatic int unsigned clip_terms(input int unsigned terms,
                                               input int unsigned max_term);
        if (terms == 0 || terms >= max_term) begin
            return max_term - 1;
        end
        return terms;
    endfunction

endpackage

// File: rtl/exp_taylor_seq.sv
// Issue/collect sequencer for the Taylor-series exp core. It launches samples, truncates
// accumulation after a per-sample term budget, and buffers the result on a valid/ready stream.
module exp_taylor_seq
    import exp_seq_pkg::*;
#(
    parameter int unsigned FW       = FwDef,
    parameter int unsigned MAXTERM  = MaxTermDef,
    parameter int unsigned TW       = 4,
    parameter int unsigned DRAIN_TO = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [FW-1:0] s_data,
    input  logic [TW-1:0] s_terms,
    input  logic [FW-1:0] cfg_exp1,
    output logic [FW-1:0] core_iData,
    output logic [FW-1:0] core_exp1,
    output logic          core_iDataValid,
    output logic          core_oDataRead,
    input  logic [FW-1:0] core_oData,
    input  logic          core_oDataValid,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [FW-1:0] m_data,
    output logic          busy,
    output logic          err
);

    localparam int unsigned DW = (DRAIN_TO > 2) ? $clog2(DRAIN_TO) : 1;

    seq_state_e    state_q, state_d;
    logic [FW-1:0] idata_q, idata_d;
    logic [FW-1:0] exp1_q, exp1_d;
    logic [TW-1:0] k_q, k_d;
    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [FW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] k_in;
    logic          accept;

    assign k_in    = TW'(clip_terms(32'(s_terms), MAXTERM));
    assign s_ready = (state_q == StIdle) | ((state_q == StHold) & m_ready);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d         = state_q;
        idata_d         = idata_q;
        exp1_d          = exp1_q;
        k_d             = k_q;
        run_cnt_d       = run_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        m_data_d        = m_data_q;
        m_valid_d       = m_valid_q;
        err_d           = err_q;
        core_iDataValid = 1'b0;
        core_oDataRead  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idata_d = s_data;
                    exp1_d  = cfg_exp1;
                    k_d     = k_in;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                core_iDataValid = 1'b1;
                run_cnt_d       = TW'(1);
                state_d         = StRun;
            end
            StRun: begin
                // core_oDataValid is not looked at here: it may still hold the previous result.
                run_cnt_d = run_cnt_q + TW'(1);
                if (run_cnt_q == k_q) begin
                    core_oDataRead = 1'b1;
                    drain_cnt_d    = '0;
                    state_d        = StDrain;
                end
            end
            StDrain: begin
                core_oDataRead = 1'b1;
                drain_cnt_d    = drain_cnt_q + DW'(1);
                if (core_oDataValid) begin
                    m_data_d  = core_oData;
                    m_valid_d = 1'b1;
                    state_d   = StHold;
                end else if (drain_cnt_q == DW'(DRAIN_TO - 1)) begin
                    err_d     = 1'b1;
                    m_data_d  = core_oData;
                    m_valid_d = 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (s_valid) begin
                        idata_d = s_data;
                        exp1_d  = cfg_exp1;
                        k_d     = k_in;
                        state_d = StLaunch;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idata_q     <= '0;
            exp1_q      <= '0;
            k_q         <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idata_q     <= idata_d;
            exp1_q      <= exp1_d;
            k_q         <= k_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            err_q       <= err_d;
        end
    end

    assign core_iData = idata_q;
    assign core_exp1  = exp1_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_exp_taylor_seq.sv
// Scoreboard bench for exp_taylor_seq with a cycle-level stand-in for the exp core.
// The core raises oDataValid two cycles after oDataRead and keeps it until one cycle after launch.
module tb_exp_taylor_seq;

    localparam logic [11:0] E = 12'h2B7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic [3:0]  s_terms;
    logic [11:0] core_iData;
    logic [11:0] core_exp1;
    logic        core_iDataValid;
    logic        core_oDataRead;
    logic [11:0] core_oData;
    logic        core_oDataValid;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic        busy;
    logic        err;

    logic        stub;
    logic [11:0] acc_q;
    logic        rd_q, iv_q, vld_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    exp_taylor_seq dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_terms(s_terms), .cfg_exp1(E), .core_iData(core_iData), .core_exp1(core_exp1),
        .core_iDataValid(core_iDataValid), .core_oDataRead(core_oDataRead),
        .core_oData(core_oData), .core_oDataValid(core_oDataValid), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .err(err)
    );

    // Core stand-in: loads on iDataValid, adds exp1 each cycle while oDataRead is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rd_q  <= 1'b0;
            iv_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            rd_q <= core_oDataRead;
            iv_q <= core_iDataValid;
            if (core_iDataValid) acc_q <= core_iData;
            else if (!core_oDataRead) acc_q <= acc_q + core_exp1;
            if (rd_q) vld_q <= 1'b1;
            else if (iv_q) vld_q <= 1'b0;
        end
    end
    assign core_oData      = acc_q;
    assign core_oDataValid = stub ? 1'b0 : vld_q;

    function automatic int clip_k(input logic [3:0] t);
        return (t == 0 || t >= 8) ? 7 : int'(t);
    endfunction

    function automatic logic [11:0] model(input logic [11:0] x, input logic [3:0] t);
        return x + 12'((clip_k(t) - 1) * int'(E));
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: result %h arrived with no expected entry", m_data);
            end else begin
                logic [11:0] want;
                want = sb.pop_front();
                if (m_data !== want) begin
                    n_fail++;
                    $display("FAIL sb_data: m_data got %h want %h", m_data, want);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_terms = '0; m_ready = 1'b1; stub = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        n_checks++;
        if ({m_valid, m_data, core_iData, core_exp1, err, busy, core_iDataValid, core_oDataRead}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mv=%b md=%h id=%h e1=%h err=%b busy=%b iv=%b rd=%b want all 0",
                     m_valid, m_data, core_iData, core_exp1, err, busy, core_iDataValid,
                     core_oDataRead);
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One sample from IDLE; checks launch, read window, result latency and err.
    task automatic run_one(input string name, input logic [11:0] x, input logic [3:0] t,
                           input int lat, input logic exp_err);
        int          k;
        int          mv;
        logic [31:0] ivm, rdm, rd_want;
        logic        both;
        k = clip_k(t); mv = -1; ivm = '0; rdm = '0; rd_want = '0; both = 1'b0;
        for (int i = k + 1; i < lat; i++) rd_want[i] = 1'b1;
        @(posedge clk); #1;
        s_data = x; s_terms = t; s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_s_ready: got %b want 1", name, s_ready);
                end
                sb.push_back(model(x, t));
            end
            if (core_iDataValid) ivm[c] = 1'b1;
            if (core_oDataRead) rdm[c] = 1'b1;
            if (core_iDataValid && core_oDataRead) both = 1'b1;
            if (m_valid && mv < 0) mv = c;
            @(posedge clk); #1;
            if (c == 0) s_valid = 1'b0;
        end
        n_checks++;
        if (mv != lat) begin
            n_fail++;
            $display("FAIL %s_latency: m_valid cycle got %0d want %0d", name, mv, lat);
        end
        n_checks++;
        if (ivm !== 32'h2) begin
            n_fail++;
            $display("FAIL %s_idatavalid: cycle mask got %h want %h", name, ivm, 32'h2);
        end
        n_checks++;
        if (rdm !== rd_want) begin
            n_fail++;
            $display("FAIL %s_odataread: cycle mask got %h want %h", name, rdm, rd_want);
        end
        n_checks++;
        if (both !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_exclusive: iDataValid and oDataRead overlap got 1 want 0", name);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: got %b want %b", name, err, exp_err);
        end
    endtask

    task automatic test_backpressure();
        int          waited;
        logic [11:0] want;
        want = model(12'h123, 4'd2);
        m_ready = 1'b0;
        @(posedge clk); #1;
        s_data = 12'h123; s_terms = 4'd2; s_valid = 1'b1;
        @(negedge clk);
        sb.push_back(want);
        @(posedge clk); #1 s_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!m_valid && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        n_checks++;
        if (!m_valid) begin
            n_fail++;
            $display("FAIL bp_wait: m_valid got 0 want 1 within 20 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== want || s_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got mv=%b md=%h sr=%b busy=%b want 1 %h 0 1",
                         i, m_valid, m_data, s_ready, busy, want);
            end
            @(posedge clk); #1;
            if (i == 4) m_ready = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: m_valid got %b want 1", m_valid);
        end
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drop: got mv=%b busy=%b want 0 0", m_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hsm, ivm, mvm;
        int          hs;
        hsm = '0; ivm = '0; mvm = '0; hs = 0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_data = 12'h0A5; s_terms = 4'd2; s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_valid && s_ready) begin
                hsm[c] = 1'b1;
                hs++;
                sb.push_back(model(s_data, s_terms));
            end
            if (core_iDataValid) ivm[c] = 1'b1;
            if (m_valid) mvm[c] = 1'b1;
            @(posedge clk); #1;
            if (hs == 1) begin
                s_data = 12'h7F1; s_terms = 4'd3;
            end else if (hs == 2) begin
                s_valid = 1'b0;
            end
        end
        n_checks++;
        if (hsm !== 32'h41) begin
            n_fail++;
            $display("FAIL b2b_handshake: cycle mask got %h want %h", hsm, 32'h41);
        end
        n_checks++;
        if (ivm !== 32'h82) begin
            n_fail++;
            $display("FAIL b2b_idatavalid: cycle mask got %h want %h", ivm, 32'h82);
        end
        n_checks++;
        if (mvm !== 32'h2040) begin
            n_fail++;
            $display("FAIL b2b_m_valid: cycle mask got %h want %h", mvm, 32'h2040);
        end
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        bad = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_data = 12'h355; s_terms = 4'd7; s_valid = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_data, core_iData, core_exp1, err, busy, core_iDataValid, core_oDataRead}
            !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got mv=%b md=%h id=%h e1=%h err=%b busy=%b iv=%b rd=%b want all 0",
                     m_valid, m_data, core_iData, core_exp1, err, busy, core_iDataValid,
                     core_oDataRead);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (s_ready !== 1'b1 || m_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: s_ready/m_valid deviated got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        run_one("basic_k3", 12'h400, 4'd3, 7, 1'b0);
        run_one("clip_0", 12'h2C8, 4'd0, 11, 1'b0);
        run_one("clip_9", 12'h9E3, 4'd9, 11, 1'b0);
        run_one("min_k1", 12'h111, 4'd1, 5, 1'b0);
        test_backpressure();
        test_back_to_back();
        stub = 1'b1;
        run_one("timeout", 12'h5A5, 4'd2, 7, 1'b1);
        stub = 1'b0;
        run_one("err_sticky", 12'h0F0, 4'd5, 9, 1'b1);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: pending entries got %0d want 0", sb.size());
        end
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time got 200000 want less");
        $fatal(1, "watchdog expired");
    end

endmodule
